// File: rtl/booth_mul_iter.sv
// rtl/booth_mul_iter.sv - iterative radix-4 Booth multiplier, DIGITS_PER_CYCLE digits per clock
module booth_mul_iter #(
  parameter int WIDTH            = 32,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 is_signed,
  input  logic                 low_only,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int ND    = WIDTH / 2 + 1;
  localparam int NL    = WIDTH / 2;
  localparam int ACC_W = 2 * WIDTH + 4;
  // Multiplier register holds the implicit bit -1 at bit 0, plus padding so the
  // last group of digits can always be sliced even when it runs past the operand.
  localparam int BW    = WIDTH + 3 + 2 * DIGITS_PER_CYCLE;
  localparam int DW    = $clog2(ND + DIGITS_PER_CYCLE) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] a_sh;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W-1:0] pp;
  logic [BW-1:0]    b_sh;
  logic [DW-1:0]    digit_idx;
  logic [DW-1:0]    digit_lim;
  logic [2:0]       dsel;
  logic             low_q;
  logic             last_step;
  logic             zero_op;
  logic             a_fill;
  logic             b_fill;
  logic [ACC_W-1:0] a_load;
  logic [BW-1:0]    b_load;

  assign a_fill  = is_signed & multiplicand[WIDTH-1];
  assign b_fill  = is_signed & multiplier[WIDTH-1];
  assign a_load  = {{(ACC_W - WIDTH){a_fill}}, multiplicand};
  assign b_load  = {{(BW - WIDTH - 1){b_fill}}, multiplier, 1'b0};
  assign zero_op = (multiplicand == '0) || (multiplier == '0);

  assign digit_lim = low_q ? DW'(NL) : DW'(ND);
  assign last_step = (digit_idx + DW'(DIGITS_PER_CYCLE)) >= digit_lim;

  // Digits past ND (padding in the final step) are gated to contribute nothing.
  always_comb begin
    acc_nxt = acc;
    dsel    = '0;
    pp      = '0;
    for (int j = 0; j < DIGITS_PER_CYCLE; j++) begin
      dsel = b_sh[2*j +: 3];
      pp   = a_sh << (2 * j);
      if ((digit_idx + DW'(j)) < DW'(ND)) begin
        unique case (dsel)
          3'b001, 3'b010: acc_nxt = acc_nxt + pp;
          3'b011:         acc_nxt = acc_nxt + (pp << 1);
          3'b100:         acc_nxt = acc_nxt - (pp << 1);
          3'b101, 3'b110: acc_nxt = acc_nxt - pp;
          default:        acc_nxt = acc_nxt;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = zero_op ? DONE : CALC;
      end
      CALC: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      digit_idx <= '0;
      low_q     <= 1'b0;
      product   <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh      <= a_load;
            b_sh      <= b_load;
            low_q     <= low_only;
            acc       <= '0;
            digit_idx <= '0;
            product   <= '0;
          end
        end
        CALC: begin
          acc       <= acc_nxt;
          a_sh      <= a_sh << (2 * DIGITS_PER_CYCLE);
          b_sh      <= b_sh >> (2 * DIGITS_PER_CYCLE);
          digit_idx <= digit_idx + DW'(DIGITS_PER_CYCLE);
          if (last_step) begin
            product <= low_q ? {{WIDTH{1'b0}}, acc_nxt[WIDTH-1:0]} : acc_nxt[2*WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_iter.sv
// tb/tb_booth_mul_iter.sv - self-checking bench for booth_mul_iter at 1, 2 and 4 digits per cycle
module tb_booth_mul_iter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] multiplicand = '0;
  logic [15:0] multiplier = '0;
  logic        is_signed = 1'b0;
  logic        low_only = 1'b0;
  logic        out_ready = 1'b0;
  int          sel = 0;

  logic [2:0]  iv_v, ir_v, ov_v, or_v, busy_v;
  logic [31:0] prod_v [3];
  logic        in_ready_o, out_valid_o, busy_o;
  logic [31:0] product_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign iv_v[0] = in_valid && (sel == 0);
  assign iv_v[1] = in_valid && (sel == 1);
  assign iv_v[2] = in_valid && (sel == 2);
  assign or_v[0] = out_ready && (sel == 0);
  assign or_v[1] = out_ready && (sel == 1);
  assign or_v[2] = out_ready && (sel == 2);
  assign in_ready_o  = ir_v[sel];
  assign out_valid_o = ov_v[sel];
  assign busy_o      = busy_v[sel];
  assign product_o   = prod_v[sel];

  booth_mul_iter #(.WIDTH(16), .DIGITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rstn(rstn), .in_valid(iv_v[0]), .in_ready(ir_v[0]),
    .multiplicand(multiplicand), .multiplier(multiplier), .is_signed(is_signed),
    .low_only(low_only), .out_valid(ov_v[0]), .out_ready(or_v[0]),
    .product(prod_v[0]), .busy(busy_v[0])
  );

  booth_mul_iter #(.WIDTH(16), .DIGITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rstn(rstn), .in_valid(iv_v[1]), .in_ready(ir_v[1]),
    .multiplicand(multiplicand), .multiplier(multiplier), .is_signed(is_signed),
    .low_only(low_only), .out_valid(ov_v[1]), .out_ready(or_v[1]),
    .product(prod_v[1]), .busy(busy_v[1])
  );

  booth_mul_iter #(.WIDTH(16), .DIGITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(iv_v[2]), .in_ready(ir_v[2]),
    .multiplicand(multiplicand), .multiplier(multiplier), .is_signed(is_signed),
    .low_only(low_only), .out_valid(ov_v[2]), .out_ready(or_v[2]),
    .product(prod_v[2]), .busy(busy_v[2])
  );

  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b,
                                           input logic sgn, input logic low);
    longint ea, eb, p;
    ea = sgn ? longint'($signed(a)) : longint'(a);
    eb = sgn ? longint'($signed(b)) : longint'(b);
    p  = ea * eb;
    return low ? {16'h0000, p[15:0]} : p[31:0];
  endfunction

  function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b,
                                 input logic low, input int dpc);
    int n;
    if (a == 16'h0 || b == 16'h0) return 1;
    n = low ? 8 : 9;
    return (n + dpc - 1) / dpc + 1;
  endfunction

  // Drives one operation on the selected instance; operand pins are scrambled after accept.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                        input logic low, output logic [31:0] p, output int lat);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    is_signed    = sgn;
    low_only     = low;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    multiplicand = 16'($urandom);
    multiplier   = 16'($urandom);
    is_signed    = 1'($urandom);
    low_only     = 1'($urandom);
    lat = 1;
    while (!out_valid_o && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid_o) lat = -1;
    p = product_o;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      checks++;
      if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || busy_o !== 1'b0 || product_o !== 32'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d got ir=%b ov=%b busy=%b p=%h want ir=1 ov=0 busy=0 p=0",
                 k, in_ready_o, out_valid_o, busy_o, product_o);
      end
    end
    sel = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_unsigned_full(input int s, input int dpc);
    logic [31:0] p;
    int lat;
    sel = s;
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, p, lat);
    checks++;
    if (p !== 32'hFFFE0001) begin
      errors++;
      $display("FAIL unsigned_full_prod dut%0d got %h want fffe0001", s, p);
    end
    checks++;
    if (lat != ref_lat(16'hFFFF, 16'hFFFF, 1'b0, dpc)) begin
      errors++;
      $display("FAIL unsigned_full_lat dut%0d got %0d want %0d", s, lat, ref_lat(16'hFFFF, 16'hFFFF, 1'b0, dpc));
    end
  endtask

  task automatic test_signed_full(input int s);
    logic [31:0] p;
    int lat;
    sel = s;
    run_op(16'h8000, 16'h7FFF, 1'b1, 1'b0, p, lat);
    checks++;
    if (p !== 32'hC0008000) begin
      errors++;
      $display("FAIL signed_min_max dut%0d got %h want c0008000", s, p);
    end
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0, p, lat);
    checks++;
    if (p !== 32'h40000000) begin
      errors++;
      $display("FAIL signed_min_min dut%0d got %h want 40000000", s, p);
    end
  endtask

  task automatic test_low_only(input int s, input int dpc);
    logic [31:0] p;
    int lat;
    sel = s;
    run_op(16'h1234, 16'h5678, 1'b0, 1'b1, p, lat);
    checks++;
    if (p !== 32'h00000060 || lat != ref_lat(16'h1234, 16'h5678, 1'b1, dpc)) begin
      errors++;
      $display("FAIL low_only dut%0d got p=%h lat=%0d want p=00000060 lat=%0d",
               s, p, lat, ref_lat(16'h1234, 16'h5678, 1'b1, dpc));
    end
    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, p, lat);
    checks++;
    if (p !== 32'h06260060 || lat != ref_lat(16'h1234, 16'h5678, 1'b0, dpc)) begin
      errors++;
      $display("FAIL full_same_ops dut%0d got p=%h lat=%0d want p=06260060 lat=%0d",
               s, p, lat, ref_lat(16'h1234, 16'h5678, 1'b0, dpc));
    end
  endtask

  task automatic test_zero_skip();
    logic [31:0] p;
    int lat;
    sel = 0;
    run_op(16'h0000, 16'hABCD, 1'b1, 1'b0, p, lat);
    checks++;
    if (p !== 32'h0 || lat != 1) begin
      errors++;
      $display("FAIL zero_skip got p=%h lat=%0d want p=0 lat=1", p, lat);
    end
    run_op(16'h8001, 16'h0000, 1'b0, 1'b1, p, lat);
    checks++;
    if (p !== 32'h0 || lat != 1) begin
      errors++;
      $display("FAIL zero_skip_b got p=%h lat=%0d want p=0 lat=1", p, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held, exp;
    int cyc;
    sel = 0;
    exp = ref_prod(16'hF00D, 16'h1357, 1'b1, 1'b0);
    @(negedge clk);
    multiplicand = 16'hF00D;
    multiplier   = 16'h1357;
    is_signed    = 1'b1;
    low_only     = 1'b0;
    in_valid     = 1'b1;
    out_ready    = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid_o && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    held = product_o;
    checks++;
    if (out_valid_o !== 1'b1 || held !== exp) begin
      errors++;
      $display("FAIL bp_result got ov=%b p=%h want ov=1 p=%h", out_valid_o, held, exp);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid     = 1'b1;
      multiplicand = 16'($urandom);
      multiplier   = 16'($urandom | 1);
      @(posedge clk);
      #1;
      checks++;
      if (product_o !== held || in_ready_o !== 1'b0 || busy_o !== 1'b1 || out_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cyc%0d got p=%h ir=%b busy=%b ov=%b want p=%h ir=0 busy=1 ov=1",
                 k, product_o, in_ready_o, busy_o, out_valid_o, held);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got ir=%b ov=%b busy=%b want ir=1 ov=0 busy=0",
               in_ready_o, out_valid_o, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p;
    logic [15:0] a, b;
    logic sg, lo;
    int lat;
    sel = 0;
    for (int k = 0; k < 6; k++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      sg = k[0];
      lo = k[1];
      run_op(a, b, sg, lo, p, lat);
      checks++;
      if (p !== ref_prod(a, b, sg, lo) || lat != ref_lat(a, b, lo, 1)) begin
        errors++;
        $display("FAIL back_to_back%0d a=%h b=%h s=%b l=%b got p=%h lat=%0d want p=%h lat=%0d",
                 k, a, b, sg, lo, p, lat, ref_prod(a, b, sg, lo), ref_lat(a, b, lo, 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p;
    int lat;
    bit seen;
    sel = 0;
    @(negedge clk);
    multiplicand = 16'hFFFF;
    multiplier   = 16'hFFFF;
    is_signed    = 1'b0;
    low_only     = 1'b0;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || product_o !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b ir=%b ov=%b p=%h want busy=0 ir=1 ov=0 p=0",
               busy_o, in_ready_o, out_valid_o, product_o);
    end
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid_o) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_reset_no_result got out_valid=1 want 0");
    end
    run_op(16'd3, 16'd5, 1'b0, 1'b0, p, lat);
    checks++;
    if (p !== 32'd15 || lat != 10) begin
      errors++;
      $display("FAIL after_reset got p=%h lat=%0d want p=0000000f lat=10", p, lat);
    end
  endtask

  task automatic test_random(input int s, input int dpc);
    logic [31:0] p;
    logic [15:0] a, b;
    logic sg, lo;
    int lat;
    sel = s;
    for (int k = 0; k < 20; k++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      sg = 1'($urandom);
      lo = 1'($urandom);
      if (k == 0) begin a = 16'h8000; b = 16'h8000; sg = 1'b1; lo = 1'b0; end
      if (k == 1) begin a = 16'hFFFF; b = 16'hFFFF; sg = 1'b0; lo = 1'b0; end
      if (k == 2) begin a = 16'hFFFF; b = 16'h8000; sg = 1'b1; lo = 1'b1; end
      if (k == 3) begin a = 16'h7FFF; b = 16'hFFFF; sg = 1'b1; lo = 1'b0; end
      run_op(a, b, sg, lo, p, lat);
      checks++;
      if (p !== ref_prod(a, b, sg, lo) || lat != ref_lat(a, b, lo, dpc)) begin
        errors++;
        $display("FAIL random dut%0d a=%h b=%h s=%b l=%b got p=%h lat=%0d want p=%h lat=%0d",
                 s, a, b, sg, lo, p, lat, ref_prod(a, b, sg, lo), ref_lat(a, b, lo, dpc));
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_full(0, 1);
    test_signed_full(0);
    test_low_only(0, 1);
    test_zero_skip();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_unsigned_full(1, 2);
    test_signed_full(1);
    test_low_only(1, 2);
    test_unsigned_full(2, 4);
    test_low_only(2, 4);
    test_random(0, 1);
    test_random(1, 2);
    test_random(2, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
